// File: rtl/srl_fifo64x12_pkg.sv
// Shared sizes for the 64 x 12 shift-register FIFO.
// The top module's optional output register is enabled by defining SRL_FIFO_OREG_EN.
package srl_fifo64x12_pkg;
    localparam int SRL_DEPTH = 64;
    localparam int SRL_WIDTH = 12;
    localparam int SRL_AW    = 6;
    localparam int SRL_CW    = 7;
endpackage

// File: rtl/srl_store64x12.sv
// Storage only: 12 addressable 64-deep shift registers sharing address and shift enable.
// Stage 0 is the newest word. The contents are never reset.
module srl_store64x12
    import srl_fifo64x12_pkg::*;
(
    input  logic                 clk,
    input  logic                 ce,
    input  logic [SRL_AW-1:0]    a,
    input  logic [SRL_WIDTH-1:0] d,
    output logic [SRL_WIDTH-1:0] y
);

    for (genvar b = 0; b < SRL_WIDTH; b++) begin : g_bit
        logic [SRL_DEPTH-1:0] sr;

        always_ff @(posedge clk) begin
            if (ce) begin
                sr <= {sr[SRL_DEPTH-2:0], d[b]};
            end
        end

        assign y[b] = sr[a];
    end

endmodule

// File: rtl/srl_fifo64x12.sv
// First-word-fall-through FIFO read controller around a 64 x 12 addressable shift register.
// Define SRL_FIFO_OREG_EN to add a registered output stage (capacity 65).
module srl_fifo64x12
    import srl_fifo64x12_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SRL_WIDTH-1:0] d,
    input  logic                 wr,
    output logic                 full,
    output logic                 ovf,
    output logic [SRL_WIDTH-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [SRL_CW-1:0]    count
);

    logic [SRL_CW-1:0]    cnt;
    logic [SRL_CW-1:0]    cnt_m1;
    logic [SRL_AW-1:0]    a;
    logic [SRL_WIDTH-1:0] y_p0;
    logic                 spop;
    logic                 push;
    logic                 ovf_r;

    // Read address always points at the oldest stored word.
    assign cnt_m1 = cnt - SRL_CW'(1);
    assign a      = cnt_m1[SRL_AW-1:0];
    assign full   = (cnt == SRL_CW'(SRL_DEPTH));
    assign count  = cnt;
    assign ovf    = ovf_r;

    srl_store64x12 u_store (
        .clk (clk),
        .ce  (push),
        .a   (a),
        .d   (d),
        .y   (y_p0)
    );

`ifdef SRL_FIFO_OREG_EN
    logic [SRL_WIDTH-1:0] y_p1;
    logic                 vld_p1;
    logic                 pop;

    assign pop     = vld_p1 && y_ready;
    // Storage is popped into the output register whenever that register is free or draining.
    assign spop    = (cnt != '0) && (!vld_p1 || pop);
    assign y       = y_p1;
    assign y_valid = vld_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (spop) begin
            vld_p1 <= 1'b1;
        end else if (pop) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (spop) begin
            y_p1 <= y_p0;
        end
    end
`else
    assign spop    = (cnt != '0) && y_ready;
    assign y       = y_p0;
    assign y_valid = (cnt != '0);
`endif

    // A write at full still lands when the oldest word leaves in the same cycle.
    assign push = wr && (!full || spop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (wr && full && !spop) begin
                ovf_r <= 1'b1;
            end
            case ({push, spop})
                2'b10:   cnt <= cnt + SRL_CW'(1);
                2'b01:   cnt <= cnt - SRL_CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_srl_fifo64x12.sv
// Directed bench for srl_fifo64x12 in its default build (no output register).
`timescale 1ns/1ps
module tb_srl_fifo64x12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] d = '0;
    logic        wr = 1'b0;
    logic        y_ready = 1'b0;
    logic        full;
    logic        ovf;
    logic [11:0] y;
    logic        y_valid;
    logic [6:0]  count;

    int checks = 0;
    int errors = 0;

    srl_fifo64x12 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .wr      (wr),
        .full    (full),
        .ovf     (ovf),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] d;
        logic        rdy;
        int          cnt;
        logic        vld;
        logic [11:0] y;
        logic        chk_y;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr = 1'b0; y_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic fill64();
        for (int i = 0; i < 64; i++) begin
            wr = 1'b1; d = 12'(12'h100 + i); y_ready = 1'b0;
            step();
        end
        wr = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [11:0] exp);
        wr = 1'b0; y_ready = 1'b1;
        chk({name, "_valid"}, int'(y_valid), 1);
        chk(name, int'(y), int'(exp));
        step();
        y_ready = 1'b0;
    endtask

    initial begin
        int bad;
        vecs[0] = '{1'b1, 12'h001, 1'b0, 1, 1'b1, 12'h001, 1'b1};
        vecs[1] = '{1'b1, 12'h002, 1'b0, 2, 1'b1, 12'h001, 1'b1};
        vecs[2] = '{1'b1, 12'h003, 1'b0, 3, 1'b1, 12'h001, 1'b1};
        vecs[3] = '{1'b1, 12'h004, 1'b0, 4, 1'b1, 12'h001, 1'b1};
        vecs[4] = '{1'b1, 12'h005, 1'b0, 5, 1'b1, 12'h001, 1'b1};
        vecs[5] = '{1'b0, 12'h000, 1'b1, 4, 1'b1, 12'h002, 1'b1};
        vecs[6] = '{1'b0, 12'h000, 1'b1, 3, 1'b1, 12'h003, 1'b1};
        vecs[7] = '{1'b0, 12'h000, 1'b1, 2, 1'b1, 12'h004, 1'b1};
        vecs[8] = '{1'b0, 12'h000, 1'b1, 1, 1'b1, 12'h005, 1'b1};
        vecs[9] = '{1'b0, 12'h000, 1'b1, 0, 1'b0, 12'h000, 1'b0};

        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(y_valid), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Five writes, then drain them in order.
        for (int i = 0; i < 10; i++) begin
            wr = vecs[i].wr; d = vecs[i].d; y_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d_valid", i), int'(y_valid), int'(vecs[i].vld));
            chk($sformatf("vec%0d_ovf", i), int'(ovf), 0);
            if (vecs[i].chk_y) chk($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].y));
        end
        wr = 1'b0; y_ready = 1'b0;

        // Overflow: write at full with no pop is dropped.
        do_reset();
        fill64();
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 64);
        chk("fill_y", int'(y), 12'h100);
        wr = 1'b1; d = 12'hFFF; y_ready = 1'b0;
        step();
        wr = 1'b0;
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_count", int'(count), 64);
        for (int i = 0; i < 64; i++) pop_check($sformatf("ovf_drain%0d", i), 12'(12'h100 + i));
        chk("ovf_drain_empty", int'(y_valid), 0);
        chk("ovf_drain_count", int'(count), 0);
        chk("ovf_sticky", int'(ovf), 1);

        // Simultaneous write and pop at full.
        do_reset();
        fill64();
        wr = 1'b1; d = 12'hABC; y_ready = 1'b1;
        step();
        wr = 1'b0; y_ready = 1'b0;
        chk("wp_y", int'(y), 12'h101);
        chk("wp_count", int'(count), 64);
        chk("wp_ovf", int'(ovf), 0);
        chk("wp_full", int'(full), 1);
        for (int i = 1; i < 64; i++) pop_check($sformatf("wp_drain%0d", i), 12'(12'h100 + i));
        pop_check("wp_abc", 12'hABC);
        chk("wp_empty", int'(y_valid), 0);

        // Streaming ramp at one word per cycle.
        do_reset();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            wr = 1'b1; d = 12'(i); y_ready = 1'b1;
            if (i >= 1) begin
                if (!y_valid || y != 12'(i - 1)) begin
                    errors++;
                    $display("FAIL stream_word%0d got valid=%0d y=0x%0h expected 0x%0h", i - 1, y_valid, y, i - 1);
                end
                checks++;
                if (count != 7'd1) bad++;
            end
            step();
        end
        wr = 1'b0;
        pop_check("stream_last", 12'd199);
        chk("stream_count_const", bad, 0);
        chk("stream_empty", int'(y_valid), 0);

        // Reset mid-operation.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            wr = 1'b1; d = 12'(12'h200 + i); y_ready = 1'b0;
            step();
        end
        wr = 1'b0;
        chk("mid_count", int'(count), 30);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(y_valid), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        wr = 1'b1; d = 12'h055;
        step();
        wr = 1'b0;
        chk("mid_after_count", int'(count), 1);
        pop_check("mid_after_y", 12'h055);
        chk("mid_final_empty", int'(y_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
